// File: rtl/gift_dec_round_key_reader.sv
// Stores GIFT-128 decryption round keys as they are generated and replays them
// newest-first, one per valid/ready handshake, to the decryption round datapath.
module gift_dec_round_key_reader #(
  parameter int ROUNDS = 40,
  parameter int KEY_W  = 128,
  parameter int RC_W   = 6,
  parameter int CNT_W  = 6
) (
  input  logic                    inClk,
  input  logic                    inRstN,
  input  logic                    inClear,
  input  logic                    inWrValid,
  input  logic [KEY_W+RC_W+1:0]   inWrData,
  output logic                    outWrReady,
  input  logic                    inStart,
  output logic                    outKeyValid,
  input  logic                    inKeyReady,
  output logic [KEY_W-1:0]        outRoundKey,
  output logic [RC_W-1:0]         outRoundConst,
  output logic                    outLast,
  output logic                    outDone,
  output logic [CNT_W-1:0]        outCount,
  output logic                    outFull,
  output logic                    outFmtErr
);

  localparam int WORD_W = KEY_W + 2 + RC_W;

  typedef enum logic [1:0] {S_LOAD, S_FULL, S_READ} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [KEY_W-1:0]  r_mem_key [ROUNDS];
  logic [RC_W-1:0]   r_mem_rc  [ROUNDS];
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_ptr;
  logic              r_fmt_err;
  logic              r_done;

  logic              w_wr_ready;
  logic              w_key_valid;
  logic              w_wr_en;
  logic              w_start_rd;
  logic              w_consume;
  logic              w_ptr_zero;
  logic [KEY_W-1:0]  w_rd_key;
  logic [RC_W-1:0]   w_rd_rc;
  logic              w_flush;

  assign w_flush    = !inRstN || inClear;
  assign w_ptr_zero = (r_ptr == '0);

  always_ff @(posedge inClk) begin
    if (w_flush) r_state <= S_LOAD;
    else         r_state <= w_state_nxt;
  end

  // A start in LOAD wins over a simultaneous write so ptr sees the pre-write count.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_ready  = 1'b0;
    w_key_valid = 1'b0;
    w_wr_en     = 1'b0;
    w_start_rd  = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_wr_ready = (r_count < CNT_W'(ROUNDS));
        if (inStart && (r_count != '0)) begin
          w_start_rd  = 1'b1;
          w_state_nxt = S_READ;
        end else if (inWrValid && w_wr_ready) begin
          w_wr_en = 1'b1;
          if (r_count == CNT_W'(ROUNDS - 1)) w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (inStart) begin
          w_start_rd  = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        w_key_valid = 1'b1;
        if (inKeyReady) begin
          w_consume = 1'b1;
          if (w_ptr_zero) w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge inClk) begin
    if (w_flush) begin
      r_count   <= '0;
      r_ptr     <= '0;
      r_fmt_err <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_consume && w_ptr_zero;
      if (w_wr_en) begin
        r_count <= r_count + CNT_W'(1);
        if (inWrData[RC_W+1:RC_W] != 2'b00) r_fmt_err <= 1'b1;
      end
      if (w_start_rd) r_ptr <= r_count - CNT_W'(1);
      if (w_consume) begin
        if (w_ptr_zero) begin
          r_count <= '0;
        end else begin
          r_ptr   <= r_ptr - CNT_W'(1);
          r_count <= r_count - CNT_W'(1);
        end
      end
    end
  end

  // Storage carries no reset; the padding bits are checked on entry but never kept.
  always_ff @(posedge inClk) begin
    if (w_wr_en) begin
      r_mem_key[r_count] <= inWrData[WORD_W-1 -: KEY_W];
      r_mem_rc[r_count]  <= inWrData[RC_W-1:0];
    end
  end

  assign w_rd_key = r_mem_key[r_ptr];
  assign w_rd_rc  = r_mem_rc[r_ptr];

  assign outWrReady    = w_wr_ready;
  assign outKeyValid   = w_key_valid;
  assign outRoundKey   = w_key_valid ? w_rd_key : '0;
  assign outRoundConst = w_key_valid ? w_rd_rc : '0;
  assign outLast       = w_key_valid && w_ptr_zero;
  assign outDone       = r_done;
  assign outCount      = r_count;
  assign outFull       = (r_count == CNT_W'(ROUNDS));
  assign outFmtErr     = r_fmt_err;

endmodule
